uart_tx_buf: RTL and testbench

UART transmitter with a small byte FIFO. It serializes bytes as 8N1 frames: start bit 0, eight data bits LSB first, stop bit 1, each bit lasting BAUD_DIV clocks (19200 baud at 50 MHz by default). The FIFO lets the upstream command/response logic queue several bytes without waiting on the line. It is the transmit-side counterpart of the system's UART receiver and drives the same serial link.

---
 rtl/uart_tx_buf.sv | 133 +++++++++++++
 tb/tb_uart_tx_buf.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// UART 8N1 transmitter fed by a small circular byte FIFO.
// Frames are sent back-to-back while bytes are queued; tx_done flags a drained queue.
module uart_tx_buf #(
  parameter int BAUD_DIV = 2604,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       full,
  output logic       busy,
  output logic       tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [11:0]   BAUD_LAST = 12'(BAUD_DIV - 1);

  typedef enum logic {IDLE, TRANS} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [9:0]    shift_q, shift_d;
  logic [11:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_done_q, tx_done_d;

  logic push, pop, load, empty, strobe, frame_end;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state_q == TRANS);
  assign TX        = shift_q[0];
  assign tx_done   = tx_done_q;
  // A push is judged against the registered fill level, so a pop in the
  // same cycle does not rescue a push made while full.
  assign push      = trmt & ~full;
  assign strobe    = busy & (baud_cnt_q == BAUD_LAST);
  assign frame_end = strobe & (bit_cnt_q == 4'd9);
  assign pop       = load;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = TRANS;
        end
      end
      TRANS: begin
        if (frame_end) begin
          if (!empty) load    = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (load) begin
      shift_d    = {1'b1, mem_q[rd_ptr_q], 1'b0};
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (busy) begin
      if (strobe) begin
        shift_d    = {1'b1, shift_q[9:1]};
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        baud_cnt_d = baud_cnt_q + 12'd1;
      end
    end
  end

  always_comb begin
    tx_done_d = tx_done_q;
    if (frame_end && empty) tx_done_d = 1'b1;
    if (push)               tx_done_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: frame-level reference model with per-cycle
// output checks, plus a line-decoding receiver that scoreboards bytes in order.
`timescale 1ns/1ps
module tb_uart_tx_buf;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BD;
  localparam int BD2   = 2604;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX, full, busy, tx_done;

  logic       rst2 = 1'b1;
  logic       trmt2 = 1'b0;
  logic [7:0] tx_data2 = 8'h00;
  logic       TX2, full2, busy2, tx_done2;

  uart_tx_buf #(.BAUD_DIV(BD), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .full(full), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_buf #(.BAUD_DIV(BD2), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst2), .trmt(trmt2), .tx_data(tx_data2),
    .TX(TX2), .full(full2), .busy(busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of pending bytes and a countdown of the frame on the line.
  logic [7:0] mfifo[$];
  logic [7:0] exp_q[$];
  int         rem    = 0;
  logic [7:0] cur    = 8'h00;
  logic       m_done = 1'b0;
  int         n_acc  = 0;
  int         n_rx   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mfifo.delete();
      exp_q.delete();
      rem    = 0;
      m_done = 1'b0;
    end else begin
      bit fe, st, acc;
      fe  = (rem == 1);
      st  = (rem <= 1) && (mfifo.size() > 0);
      acc = trmt && (mfifo.size() < DEPTH);
      if (st) begin
        cur = mfifo.pop_front();
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (fe && !st) m_done = 1'b1;
      if (acc) begin
        m_done = 1'b0;
        mfifo.push_back(tx_data);
        exp_q.push_back(tx_data);
        n_acc++;
      end
    end
  end

  function automatic logic exp_tx();
    logic [9:0] frm;
    int b;
    if (rem == 0) return 1'b1;
    frm = {1'b1, cur, 1'b0};
    b   = (FRAME - rem) / BD;
    return frm[b];
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("tx_line", TX, exp_tx());
      check("busy", busy, rem != 0);
      check("full", full, mfifo.size() == DEPTH);
      check("tx_done", tx_done, m_done);
    end
  end

  // Receiver: samples each bit mid-period and compares against the accepted-byte queue.
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_sh  = '0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (TX === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BD == BD / 2) begin
        int i;
        i = rx_cnt / BD;
        rx_sh[i] = TX;
        if (i == 0) check("rx_start_bit", TX, 0);
        if (i == 9) begin
          check("rx_stop_bit", TX, 1);
          check("rx_expected_frame", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", rx_sh[8:1], exp_q.pop_front());
          n_rx++;
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input int bound, output longint t_edge);
    t_edge = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (tx_done === 1'b1) begin
        t_edge = $time - 1;
        return;
      end
    end
  endtask

  logic done2 = 1'b0;

  initial begin : default_divider
    int lowcnt;
    int waited;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    trmt2 = 1'b1;
    tx_data2 = 8'h00;
    @(negedge clk);
    trmt2 = 1'b0;
    waited = 0;
    while (TX2 !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    lowcnt = 0;
    while (TX2 === 1'b0 && lowcnt < 30000) begin
      lowcnt++;
      @(negedge clk);
    end
    check("div2604_low_len", lowcnt, 9 * BD2);
    check("div2604_stop_high", TX2, 1);
    waited = 0;
    while (tx_done2 !== 1'b1 && waited < BD2 + 20) begin
      @(negedge clk);
      waited++;
    end
    check("div2604_tx_done", tx_done2, 1);
    check("div2604_idle", busy2, 0);
    done2 = 1'b1;
  end

  initial begin : main
    longint t_k, t_d;
    int base_rx, base_acc, guard;

    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_tx_done", tx_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: start at k+1, done at k+161.
    trmt = 1'b1;
    tx_data = 8'hA5;
    @(posedge clk);
    t_k = $time;
    @(negedge clk);
    trmt = 1'b0;
    wait_done(FRAME + 40, t_d);
    check("single_done_latency", 32'((t_d - t_k) / 10), FRAME + 1);
    check("single_rx_count", n_rx, 1);
    repeat (5) @(negedge clk);

    // Burst of five plus a dropped sixth.
    base_rx = n_rx;
    for (int i = 1; i <= 6; i++) begin
      trmt = 1'b1;
      tx_data = 8'(i);
      if (i == 1) begin
        @(posedge clk);
        t_k = $time;
      end
      @(negedge clk);
    end
    trmt = 1'b0;
    check("burst_full_after_drop", full, 1);
    wait_done(6 * FRAME, t_d);
    check("burst_done_latency", 32'((t_d - t_k) / 10), 5 * FRAME + 1);
    check("burst_rx_count", n_rx - base_rx, 5);
    repeat (5) @(negedge clk);

    // Push exactly on the frame_end cycle of the last byte.
    trmt = 1'b1;
    tx_data = 8'h3C;
    @(negedge clk);
    trmt = 1'b0;
    guard = 0;
    while (rem != 1 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    trmt = 1'b1;
    tx_data = 8'hC3;
    @(posedge clk);
    #1;
    check("fe_push_tx_done_low", tx_done, 0);
    check("fe_push_busy_low", busy, 0);
    @(negedge clk);
    trmt = 1'b0;
    @(posedge clk);
    #1;
    check("fe_push_restart_busy", busy, 1);
    check("fe_push_restart_start", TX, 0);
    wait_done(FRAME + 40, t_d);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 with two bytes still queued.
    for (int i = 0; i < 3; i++) begin
      trmt = 1'b1;
      tx_data = 8'hF0;
      @(negedge clk);
    end
    trmt = 1'b0;
    guard = 0;
    while (rem != FRAME - 4 * BD - 3 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_pre_tx_low", TX, 0);
    check("midrst_pre_busy", busy, 1);
    base_rx = n_rx;
    rst = 1'b1;
    #1;
    check("midrst_tx", TX, 1);
    check("midrst_busy", busy, 0);
    check("midrst_full", full, 0);
    check("midrst_tx_done", tx_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    check("midrst_no_frames", n_rx - base_rx, 0);
    check("midrst_line_idle", TX, 1);

    // Random loopback stream.
    base_rx  = n_rx;
    base_acc = n_acc;
    guard = 0;
    while (n_acc - base_acc < 256 && guard < 80000) begin
      trmt = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    trmt = 1'b0;
    guard = 0;
    while ((rem != 0 || mfifo.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("loop_accepted", (n_acc - base_acc) >= 256, 1);
    check("loop_rx_count", n_rx - base_rx, n_acc - base_acc);
    check("loop_queue_drained", exp_q.size(), 0);
    check("loop_tx_done", tx_done, 1);

    guard = 0;
    while (!done2 && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    check("div2604_completed", done2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
